// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART timing definitions used by the baud-rate generator and the
// UART TX/RX blocks.
//   SYS_CLOCK / BAUD_RATE  : default system clock and line rate
//   OVERSAMPLE_DEFAULT     : oversample ticks per bit
//   edge_action_e          : what the tick generator does on a given edge
//   calcDivisor()          : integer + fractional divisor for clock/baud
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int SYS_CLOCK          = 100_000_000;
  localparam int BAUD_RATE          = 9600;
  localparam int OVERSAMPLE_DEFAULT = 16;

  // Integer and fractional part of an oversample-tick divisor.
  typedef struct packed {
    logic [31:0] intDiv;
    logic [31:0] fracDiv;
  } divisor_t;

  // Action taken by the tick generator on one clock edge, in priority order
  // below reset: resync, hold (enable low), tick (period end), plain count.
  typedef enum logic [1:0] {
    ACT_COUNT  = 2'd0,
    ACT_TICK   = 2'd1,
    ACT_RESYNC = 2'd2,
    ACT_HOLD   = 2'd3
  } edge_action_e;

  // Rounded fixed-point divisor sysClock / (baudRate * overSample), split
  // into its integer part and an nbFrac-bit fraction.
  function automatic divisor_t calcDivisor(input int sysClock, input int baudRate,
                                           input int overSample, input int nbFrac);
    longint   denom;
    longint   scaled;
    divisor_t result;
    denom  = longint'(baudRate) * longint'(overSample);
    scaled = ((longint'(sysClock) <<< nbFrac) + denom / 2) / denom;
    result.intDiv  = 32'(scaled >>> nbFrac);
    result.fracDiv = 32'(scaled & ((longint'(1) <<< nbFrac) - 1));
    return result;
  endfunction

endpackage

// File: rtl/baud_frac_accum.sv
// ---------------------------------------------------------------------------
// baud_frac_accum
// Fractional accumulator for the baud-rate generator. On every tick it adds
// the fraction into an NB_FRAC-bit accumulator; the carry out of that add
// stretches the following period by one clock.
// Ports:
//   i_clock   : system clock
//   i_reset   : synchronous reset, active-low
//   i_clear   : clear accumulator and carry (resync / enable low)
//   i_step    : tick edge, accumulate i_frac
//   i_frac    : fraction to accumulate (value in force for the next period)
//   o_extend  : 1 = current period is D+1 clocks
// ---------------------------------------------------------------------------
module baud_frac_accum #(
  parameter int NB_FRAC = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_step,
  input  logic [NB_FRAC-1:0] i_frac,
  output logic               o_extend
);

  logic [NB_FRAC-1:0] r_accum;
  logic               r_carry;
  logic [NB_FRAC:0]   w_sum;

  // One extra bit on the add captures the carry out of the fraction.
  assign w_sum = {1'b0, r_accum} + {1'b0, i_frac};

  // Accumulator and period-select carry. The carry produced on a tick edge
  // applies to the period that starts on that edge; clearing drops any
  // partially accumulated fraction so timing restarts from a clean phase.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_accum <= '0;
      r_carry <= 1'b0;
    end else if (i_clear) begin
      r_accum <= '0;
      r_carry <= 1'b0;
    end else if (i_step) begin
      r_accum <= w_sum[NB_FRAC-1:0];
      r_carry <= w_sum[NB_FRAC];
    end
  end

  assign o_extend = r_carry;

endmodule

// File: rtl/baudrate_generator_frac.sv
// ---------------------------------------------------------------------------
// baudrate_generator_frac
// Runtime-programmable UART oversampling tick generator. Each oversample
// period lasts D = max(divisor,1) clocks, stretched to D+1 when the
// fractional accumulator carries. An oversample index counts ticks and
// produces a once-per-bit tick and a mid-bit strobe.
//
// Optional feature macro: BAUDRATE_GEN_FRAC_EN
//   defined   : fractional accumulator and i_frac path are built
//   undefined : period is always D, i_frac is ignored
//
// Ports:
//   i_clock      : system clock, rising edge
//   i_reset      : synchronous reset, active-low
//   i_enable     : 1 = run, 0 = hold counters cleared, no ticks
//   i_divisor    : integer divisor, captured when i_load=1
//   i_frac       : fractional divisor (i_frac / 2^NB_FRAC), captured on i_load
//   i_load       : single-cycle capture request
//   i_resync     : restart bit phase (RX start-bit edge)
//   o_tick       : 1-cycle oversample tick
//   o_bit_tick   : 1-cycle pulse when the index wraps to 0
//   o_mid_tick   : 1-cycle pulse when the index reaches OVERSAMPLE/2
//   o_ovs_index  : current oversample position
//   o_pending    : load captured but not yet applied
// ---------------------------------------------------------------------------
module baudrate_generator_frac
  import uart_pkg::*;
#(
  parameter int NB_DIVISOR    = 16,
  parameter int NB_FRAC       = 4,
  parameter int OVERSAMPLE    = OVERSAMPLE_DEFAULT,
  parameter int NB_OVS        = $clog2(OVERSAMPLE),
  parameter int RESET_DIVISOR = 651,
  parameter int RESET_FRAC    = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [NB_DIVISOR-1:0] i_divisor,
  input  logic [NB_FRAC-1:0]    i_frac,
  input  logic                  i_load,
  input  logic                  i_resync,
  output logic                  o_tick,
  output logic                  o_bit_tick,
  output logic                  o_mid_tick,
  output logic [NB_OVS-1:0]     o_ovs_index,
  output logic                  o_pending
);

  // The counter needs one extra bit: a stretched period of 2^NB_DIVISOR
  // clocks must still reach its last count.
  localparam int                NB_COUNT   = NB_DIVISOR + 1;
  localparam logic [NB_OVS-1:0] LAST_INDEX = NB_OVS'(OVERSAMPLE - 1);
  localparam logic [NB_OVS-1:0] MID_PREV   = NB_OVS'(OVERSAMPLE / 2 - 1);

  logic [NB_DIVISOR-1:0] r_divisor;
  logic [NB_DIVISOR-1:0] r_pendDivisor;
  logic                  r_pending;
  logic [NB_COUNT-1:0]   r_counter;
  logic [NB_OVS-1:0]     r_index;
  logic                  r_tick;
  logic                  r_bitTick;
  logic                  r_midTick;

  logic [NB_COUNT-1:0]   w_effDivisor;
  logic [NB_COUNT-1:0]   w_lastCount;
  logic                  w_extend;
  logic                  w_apply;
  logic                  w_clear;
  logic                  w_step;
  edge_action_e          w_action;

  // A zero divisor behaves as one: a tick on every enabled edge.
  assign w_effDivisor = (r_divisor == '0) ? NB_COUNT'(1) : {1'b0, r_divisor};
  assign w_lastCount  = w_effDivisor - NB_COUNT'(1) + {{NB_DIVISOR{1'b0}}, w_extend};

  // Decide what this edge does. Resync beats enable-low, which beats the
  // normal count; reset is handled directly in the registers.
  always_comb begin
    w_action = ACT_COUNT;
    if (i_resync) begin
      w_action = ACT_RESYNC;
    end else if (!i_enable) begin
      w_action = ACT_HOLD;
    end else if (r_counter == w_lastCount) begin
      w_action = ACT_TICK;
    end
  end

  // Pending values go live at every period boundary: a tick, a resync, or
  // any edge while held, since a held generator has no period in flight.
  assign w_apply = r_pending && (w_action != ACT_COUNT);
  assign w_clear = (w_action == ACT_RESYNC) || (w_action == ACT_HOLD);
  assign w_step  = (w_action == ACT_TICK);

  // Divisor load handshake. A load always wins the pending register, so a
  // load arriving on the apply edge becomes the next pending value while the
  // older one goes live.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_divisor     <= NB_DIVISOR'(RESET_DIVISOR);
      r_pendDivisor <= '0;
      r_pending     <= 1'b0;
    end else begin
      if (w_apply) begin
        r_divisor <= r_pendDivisor;
      end
      if (i_load) begin
        r_pendDivisor <= i_divisor;
        r_pending     <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

`ifdef BAUDRATE_GEN_FRAC_EN
  logic [NB_FRAC-1:0] r_frac;
  logic [NB_FRAC-1:0] r_pendFrac;
  logic [NB_FRAC-1:0] w_fracNext;

  // The add on an apply edge already uses the new fraction, so the period
  // that starts there is governed entirely by the new settings.
  assign w_fracNext = w_apply ? r_pendFrac : r_frac;

  // Fraction registers follow the same capture/apply rules as the divisor.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_frac     <= NB_FRAC'(RESET_FRAC);
      r_pendFrac <= '0;
    end else begin
      if (w_apply) begin
        r_frac <= r_pendFrac;
      end
      if (i_load) begin
        r_pendFrac <= i_frac;
      end
    end
  end

  baud_frac_accum #(
    .NB_FRAC (NB_FRAC)
  ) u_fracAccum (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_clear),
    .i_step   (w_step),
    .i_frac   (w_fracNext),
    .o_extend (w_extend)
  );
`else
  logic w_unusedFrac;

  // Without the fractional path every period is exactly D clocks.
  assign w_extend     = 1'b0;
  assign w_unusedFrac = ^{i_frac, NB_FRAC'(RESET_FRAC), w_clear, w_step};
`endif

  // Period counter, oversample index and the registered tick strobes. The
  // strobes are decoded from the index before it advances so they line up
  // with the tick that moves the index onto 0 or OVERSAMPLE/2.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_counter <= '0;
      r_index   <= '0;
      r_tick    <= 1'b0;
      r_bitTick <= 1'b0;
      r_midTick <= 1'b0;
    end else begin
      case (w_action)
        ACT_RESYNC, ACT_HOLD: begin
          r_counter <= '0;
          r_index   <= '0;
          r_tick    <= 1'b0;
          r_bitTick <= 1'b0;
          r_midTick <= 1'b0;
        end
        ACT_TICK: begin
          r_counter <= '0;
          r_index   <= (r_index == LAST_INDEX) ? '0 : r_index + NB_OVS'(1);
          r_tick    <= 1'b1;
          r_bitTick <= (r_index == LAST_INDEX);
          r_midTick <= (r_index == MID_PREV);
        end
        default: begin
          r_counter <= r_counter + NB_COUNT'(1);
          r_tick    <= 1'b0;
          r_bitTick <= 1'b0;
          r_midTick <= 1'b0;
        end
      endcase
    end
  end

  assign o_tick      = r_tick;
  assign o_bit_tick  = r_bitTick;
  assign o_mid_tick  = r_midTick;
  assign o_ovs_index = r_index;
  assign o_pending   = r_pending;

endmodule

// File: tb/tb_baudrate_generator_frac.sv
// ---------------------------------------------------------------------------
// tb_baudrate_generator_frac
// Scoreboard bench for baudrate_generator_frac. A reference model on the
// rising edge predicts tick events from period start times and lengths and
// queues them; a monitor on the falling edge pops and compares whenever the
// DUT raises o_tick. Directed sequences then random traffic drive the DUT.
// ---------------------------------------------------------------------------
module tb_baudrate_generator_frac;

  localparam int OVS      = 16;
  localparam int FRAC_MOD = 16;
  localparam int RST_DIV  = 651;
  localparam int RST_FRAC = 1;

  typedef struct {
    longint edgeNo;
    int     index;
    bit     bitT;
    bit     midT;
  } exp_t;

  logic        i_clock;
  logic        i_reset;
  logic        i_enable;
  logic [15:0] i_divisor;
  logic [3:0]  i_frac;
  logic        i_load;
  logic        i_resync;
  logic        o_tick;
  logic        o_bit_tick;
  logic        o_mid_tick;
  logic [3:0]  o_ovs_index;
  logic        o_pending;

  int     checks = 0;
  int     errors = 0;
  longint edgeNum = 0;
  exp_t   expQ[$];

  bit     modelValid = 0;
  int     mActD = RST_DIV;
  int     mActF = RST_FRAC;
  int     mPendD = 0;
  int     mPendF = 0;
  bit     mPending = 0;
  int     mAccum = 0;
  int     mIndex = 0;
  longint mStart = 0;
  int     mLen = RST_DIV;

  baudrate_generator_frac dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_divisor   (i_divisor),
    .i_frac      (i_frac),
    .i_load      (i_load),
    .i_resync    (i_resync),
    .o_tick      (o_tick),
    .o_bit_tick  (o_bit_tick),
    .o_mid_tick  (o_mid_tick),
    .o_ovs_index (o_ovs_index),
    .o_pending   (o_pending)
  );

  // 100 MHz clock.
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Hard stop in case something stalls beyond every bounded wait.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at edge %0d", name, actual, expected, edgeNum);
    end
  endtask

  // Drive one edge's worth of inputs, return at the falling edge after it.
  task automatic applyStimulus(input logic rst, input logic en, input logic ld,
                               input logic [15:0] div, input logic [3:0] frc,
                               input logic rs);
    i_reset   = rst;
    i_enable  = en;
    i_load    = ld;
    i_divisor = div;
    i_frac    = frc;
    i_resync  = rs;
    @(negedge i_clock);
  endtask

  // Wait for the n-th occurrence of a strobe (0 tick, 1 bit, 2 mid).
  task automatic waitFor(input int kind, input int n, output longint edgeOut);
    int seen;
    seen    = 0;
    edgeOut = -1;
    for (int c = 0; c < 5000 && seen < n; c++) begin
      @(negedge i_clock);
      if ((kind == 0 && o_tick) || (kind == 1 && o_bit_tick) || (kind == 2 && o_mid_tick)) begin
        seen++;
        if (seen == n) edgeOut = edgeNum;
      end
    end
    if (seen < n) checkOutput("waitTimeout", seen, n);
  endtask

  // Load a divisor while held so it goes live immediately, then run.
  task automatic setDivisor(input logic [15:0] div, input logic [3:0] frc);
    applyStimulus(1, 0, 1, div, frc, 0);
    applyStimulus(1, 0, 0, div, frc, 0);
  endtask

  // Reference model: a period starts at mStart and lasts mLen edges; the
  // edge that completes it is a tick. Boundaries (tick, resync, hold) are
  // where pending settings go live and the next length is chosen.
  always @(posedge i_clock) begin
    bit due, apply, carry;
    int newD, newF, effD, sum;
    edgeNum++;
    if (!i_reset) begin
      mActD = RST_DIV; mActF = RST_FRAC; mPendD = 0; mPendF = 0; mPending = 0;
      mAccum = 0; mIndex = 0; mStart = edgeNum; mLen = RST_DIV; modelValid = 1;
    end else if (modelValid) begin
      due   = i_enable && !i_resync && (edgeNum - mStart == longint'(mLen));
      apply = mPending && (i_resync || !i_enable || due);
      newD  = apply ? mPendD : mActD;
      newF  = apply ? mPendF : mActF;
      effD  = (newD == 0) ? 1 : newD;
      if (i_resync || !i_enable) begin
        mAccum = 0; mIndex = 0; mStart = edgeNum; mLen = effD;
      end else if (due) begin
        mIndex = (mIndex + 1) % OVS;
        expQ.push_back('{edgeNum, mIndex, mIndex == 0, mIndex == OVS / 2});
`ifdef BAUDRATE_GEN_FRAC_EN
        sum    = mAccum + newF;
        carry  = (sum >= FRAC_MOD);
        mAccum = sum % FRAC_MOD;
`else
        sum   = 0;
        carry = 0;
`endif
        mStart = edgeNum;
        mLen   = effD + int'(carry);
      end
      if (i_load) begin
        mPendD = int'(i_divisor); mPendF = int'(i_frac); mPending = 1;
      end else if (apply) begin
        mPending = 0;
      end
      mActD = newD; mActF = newF;
    end
  end

  // Monitor: whenever the DUT presents a tick, pop the scoreboard and compare.
  always @(negedge i_clock) begin
    exp_t e;
    if (modelValid) begin
      if (o_tick) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedTick", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("tickEdge", edgeNum, e.edgeNo);
          checkOutput("tickIndex", longint'(o_ovs_index), e.index);
          checkOutput("bitTick", o_bit_tick, e.bitT);
          checkOutput("midTick", o_mid_tick, e.midT);
        end
      end else begin
        if (expQ.size() > 0 && expQ[0].edgeNo <= edgeNum) begin
          checkOutput("missedTick", 0, 1);
          void'(expQ.pop_front());
        end
        checkOutput("idleStrobes", longint'({o_bit_tick, o_mid_tick}), 0);
      end
      checkOutput("ovsIndex", longint'(o_ovs_index), mIndex);
      checkOutput("pending", o_pending, mPending);
    end
  end

  initial begin
    longint s, a, b, c, e1, e2, em;
    bit found;
    bit rst, en, ld, rs;

    i_reset = 0; i_enable = 0; i_load = 0; i_divisor = 0; i_frac = 0; i_resync = 0;
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rstTick", o_tick, 0);
    checkOutput("rstBit", o_bit_tick, 0);
    checkOutput("rstMid", o_mid_tick, 0);
    checkOutput("rstIndex", longint'(o_ovs_index), 0);
    checkOutput("rstPending", o_pending, 0);

    // Reset divisor latency.
    s = edgeNum;
    applyStimulus(1, 1, 0, 0, 0, 0);
    waitFor(0, 1, a);
    checkOutput("resetLatency", a - s, RST_DIV);

    // D=4: tick, bit and mid spacing.
    setDivisor(4, 0);
    s = edgeNum;
    applyStimulus(1, 1, 0, 0, 0, 0);
    waitFor(0, 1, a);
    checkOutput("enableLatencyD4", a - s, 4);
    waitFor(0, 1, b);
    checkOutput("tickSpacingD4", b - a, 4);
    waitFor(1, 1, e1);
    waitFor(2, 1, em);
    waitFor(1, 1, e2);
    checkOutput("bitSpacingD4", e2 - e1, 64);
    checkOutput("midAfterBitD4", em - e1, 32);

`ifdef BAUDRATE_GEN_FRAC_EN
    // D=4 + 0.5: 16 ticks span 72 clocks.
    setDivisor(4, 8);
    applyStimulus(1, 1, 0, 0, 0, 0);
    waitFor(0, 1, a);
    waitFor(0, 16, b);
    checkOutput("fracSpan16", b - a, 72);
    setDivisor(4, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
`endif

    // Load mid-period: old period finishes, then 10; double load keeps the last.
    waitFor(0, 1, a);
    applyStimulus(1, 1, 1, 10, 0, 0);
    checkOutput("pendingSet", o_pending, 1);
    applyStimulus(1, 1, 0, 0, 0, 0);
    waitFor(0, 1, b);
    checkOutput("oldPeriodKept", b - a, 4);
    checkOutput("pendingCleared", o_pending, 0);
    waitFor(0, 1, c);
    checkOutput("newPeriod10", c - b, 10);
    applyStimulus(1, 1, 1, 6, 0, 0);
    applyStimulus(1, 1, 1, 8, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    waitFor(0, 1, a);
    waitFor(0, 1, b);
    checkOutput("lastLoadWins", b - a, 8);

    // D=0 and D=1: tick every cycle, bit every 16.
    for (int d = 0; d < 2; d++) begin
      setDivisor(16'(d), 0);
      applyStimulus(1, 1, 0, 0, 0, 0);
      waitFor(0, 1, a);
      waitFor(0, 1, b);
      checkOutput("tickEveryCycle", b - a, 1);
      waitFor(1, 1, e1);
      waitFor(1, 1, e2);
      checkOutput("bitEvery16", e2 - e1, 16);
    end

    // Resync at index 11.
    setDivisor(4, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge i_clock);
      if (o_ovs_index == 4'd11) found = 1;
    end
    checkOutput("reachIndex11", found, 1);
    applyStimulus(1, 1, 0, 0, 0, 1);
    s = edgeNum;
    checkOutput("resyncNoTick", o_tick, 0);
    checkOutput("resyncIndex", longint'(o_ovs_index), 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    waitFor(2, 1, em);
    checkOutput("midAfterResync", em - s, 32);

    // Enable low for 3 cycles, then re-enable keeps D=4.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("holdOutputs", longint'({o_tick, o_bit_tick, o_mid_tick, o_ovs_index}), 0);
    end
    s = edgeNum;
    applyStimulus(1, 1, 0, 0, 0, 0);
    waitFor(0, 1, a);
    checkOutput("reenableLatency", a - s, 4);

    // Reset mid-period restores the reset divisor.
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 7, 0, 0);
    checkOutput("midResetOutputs", longint'({o_tick, o_bit_tick, o_mid_tick, o_ovs_index, o_pending}), 0);
    s = edgeNum;
    applyStimulus(1, 1, 0, 0, 0, 0);
    waitFor(0, 1, a);
    checkOutput("postResetLatency", a - s, RST_DIV);

    // Random traffic checked by the scoreboard.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 399) != 0);
      en  = ($urandom_range(0, 99) >= 3);
      ld  = ($urandom_range(0, 9) == 0);
      rs  = ($urandom_range(0, 49) == 0);
      applyStimulus(rst, en, ld, 16'($urandom_range(0, 12)), 4'($urandom_range(0, 15)), rs);
    end
    repeat (20) applyStimulus(1, 1, 0, 0, 0, 0);

    $display("[TB] run complete, %0d scoreboard entries left", expQ.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
